// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//
// HI/LO multiply-divide unit for the pipelined MIPS core. Accepts
// MULT/MULTU/DIV/DIVU/MTHI/MTLO (and optionally MADD/MADDU) requests from EX
// and sequences a radix-2 shift-add multiplier or a restoring divider, one
// bit per cycle. Owns the HI/LO registers and raises busy while an iterative
// operation is in flight so the hazard unit can stall dependent instructions.
//
// Timing of an iterative op: accepted at edge E0, XLEN iteration edges
// E1..E32, sign-fix and HI/LO write at E33. done (and div_zero) pulse for one
// cycle after E33, the same cycle busy drops.
//
// Configuration macro:
//   MULDIV_MADD_EN  when defined, op 110 (MADD) and 111 (MADDU) multiply and
//                   accumulate into {hi,lo}. When undefined those ops are
//                   ignored and no accumulate adder exists.
//
// Parameters:
//   XLEN      operand width, also the iteration count and HI/LO width (>= 2)
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset, highest priority
//   start     request valid, sampled at rising edge
//   op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//             110 MADD, 111 MADDU
//   rs        operand A / dividend / MTHI-MTLO data
//   rt        operand B / divisor
//   cancel    exception flush, aborts an in-flight operation
//   busy      high while an iterative operation is in flight
//   done      one-cycle pulse when an iterative op writes HI/LO
//   div_zero  one-cycle pulse with done when the divisor was zero
//   hi, lo    HI and LO registers
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;
`ifdef MULDIV_MADD_EN
    localparam logic [2:0] OpMadd  = 3'b110;
    localparam logic [2:0] OpMaddu = 3'b111;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } state_t;

    state_t              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [XLEN-1:0]     mag_a_q;     // multiplicand magnitude (MUL only)
    logic [XLEN-1:0]     mag_b_q;     // divisor magnitude (DIV only)
    logic                neg_res_q;   // product / quotient sign
    logic                neg_rem_q;   // remainder sign follows the dividend
    logic                is_div_q;
`ifdef MULDIV_MADD_EN
    logic                is_madd_q;
`endif
    // MUL: {partial product, remaining multiplier bits}
    // DIV: {partial remainder, remaining dividend bits / quotient bits}
    logic [2*XLEN-1:0]   acc_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            is_mul_op;
    logic            is_div_op;
    logic            is_madd_op;
    logic            is_iter_op;
    logic            op_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    always_comb begin
        is_mul_op  = (op == OpMult) || (op == OpMultu);
        is_div_op  = (op == OpDiv) || (op == OpDivu);
        is_madd_op = 1'b0;
`ifdef MULDIV_MADD_EN
        is_madd_op = (op == OpMadd) || (op == OpMaddu);
`endif
    end

    assign is_iter_op = is_mul_op || is_div_op || is_madd_op;

    // Signed variants (MULT, DIV, MADD) all have op[0] clear.
    assign op_signed = ~op[0];
    assign sign_a    = op_signed & rs[XLEN-1];
    assign sign_b    = op_signed & rt[XLEN-1];

    // The most negative value negates to itself and is then read as unsigned.
    assign mag_a = sign_a ? (~rs + 1'b1) : rs;
    assign mag_b = sign_b ? (~rt + 1'b1) : rt;

    // ------------------------------------------------------------------
    // Multiply step: add multiplicand if multiplier LSB set, shift right.
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                      (acc_q[0] ? {1'b0, mag_a_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // ------------------------------------------------------------------
    // Divide step: shift remainder left, trial-subtract, restore on borrow.
    // ------------------------------------------------------------------
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] div_next;

    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign trial    = rem_sh - {1'b0, mag_b_q};
    assign div_next = trial[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {trial[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    // ------------------------------------------------------------------
    // Sign correction
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic              div_by_zero;

    assign prod_fix    = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign quot_fix    = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    // With a zero divisor the remainder is the dividend magnitude, so
    // re-applying its sign yields the raw rs value.
    assign rem_fix     = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1)
                                   : acc_q[2*XLEN-1:XLEN];
    assign div_by_zero = (mag_b_q == '0);

`ifdef MULDIV_MADD_EN
    logic [2*XLEN-1:0] madd_sum;
    assign madd_sum = {hi, lo} + prod_fix;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
            is_madd_q <= 1'b0;
`endif
            acc_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    // cancel in the same cycle drops the request.
                    if (start && !cancel) begin
                        if (is_iter_op) begin
                            cnt_q     <= '0;
                            busy      <= 1'b1;
                            neg_res_q <= sign_a ^ sign_b;
                            neg_rem_q <= sign_a;
                            is_div_q  <= is_div_op;
`ifdef MULDIV_MADD_EN
                            is_madd_q <= is_madd_op;
`endif
                            if (is_div_op) begin
                                state_q <= StDiv;
                                mag_a_q <= mag_a;
                                mag_b_q <= mag_b;
                                acc_q   <= {{XLEN{1'b0}}, mag_a};
                            end else begin
                                state_q <= StMul;
                                mag_a_q <= mag_a;
                                mag_b_q <= mag_b;
                                acc_q   <= {{XLEN{1'b0}}, mag_b};
                            end
                        end else if (op == OpMthi) begin
                            hi <= rs;
                        end else if (op == OpMtlo) begin
                            lo <= rs;
                        end
                    end
                end

                StMul, StDiv: begin
                    if (cancel) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        acc_q <= (state_q == StMul) ? mul_next : div_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntW'(XLEN - 1)) begin
                            state_q <= StFix;
                        end
                    end
                end

                StFix: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (is_div_q) begin
                            hi       <= rem_fix;
                            lo       <= div_by_zero ? {XLEN{1'b1}} : quot_fix;
                            div_zero <= div_by_zero;
`ifdef MULDIV_MADD_EN
                        end else if (is_madd_q) begin
                            {hi, lo} <= madd_sum;
`endif
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
//
// Directed self-checking bench for muldiv_ctrl. Inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
// Compile with +define+MULDIV_MADD_EN to exercise the accumulate ops.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;
    localparam logic [2:0] OpMadd  = 3'b110;

    logic            clk;
    logic            reset;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic            cancel;
    logic            busy;
    logic            done;
    logic            div_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    int errors = 0;
    int checks = 0;

    muldiv_ctrl #(
        .XLEN(XLEN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs      (rs),
        .rt      (rt),
        .cancel  (cancel),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges with busy high, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp_hi,
                          input logic [XLEN-1:0] exp_lo, input logic exp_dz);
        int n;
        issue(o, a, b);
        wait_done(n);
        check_val({tag, ".busy_cycles"}, 64'(n), 64'd33);
        check_val({tag, ".done"}, 64'(done), 64'd1);
        check_val({tag, ".div_zero"}, 64'(div_zero), 64'(exp_dz));
        check_val({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        check_val({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        check_val({tag, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int pulses;
        int busy_seen;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'b000;
        rs     = '0;
        rt     = '0;
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst.busy", 64'(busy), 64'd0);
        check_val("rst.done", 64'(done), 64'd0);
        check_val("rst.div_zero", 64'(div_zero), 64'd0);
        check_val("rst.hi", 64'(hi), 64'd0);
        check_val("rst.lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Multiply and divide vectors
        run_op("mult_m2x3", OpMult, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        run_op("multu_fex3", OpMultu, 32'hFFFFFFFE, 32'h3, 32'h2, 32'hFFFFFFFA, 1'b0);
        run_op("multu_max", OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0);
        run_op("div_m7d2", OpDiv, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu_7d0", OpDivu, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 1'b1);
        run_op("div_ovf", OpDiv, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        run_op("divu_100d7", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // MTHI: visible next cycle, never busy, no done
        issue(OpMthi, 32'h12345678, 32'h0);
        check_val("mthi.hi", 64'(hi), 64'h12345678);
        busy_seen = 0;
        pulses    = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_seen++;
            if (done) pulses++;
            @(negedge clk);
        end
        check_val("mthi.busy", 64'(busy_seen), 64'd0);
        check_val("mthi.done", 64'(pulses), 64'd0);

        // MTLO while busy is dropped
        issue(OpMultu, 32'd5, 32'd6);
        repeat (4) @(negedge clk);
        issue(OpMtlo, 32'hDEADBEEF, 32'h0);
        wait_done(n);
        check_val("mtlo_busy.done", 64'(done), 64'd1);
        check_val("mtlo_busy.lo", 64'(lo), 64'h1E);
        check_val("mtlo_busy.hi", 64'(hi), 64'h0);
        @(negedge clk);
        check_val("mtlo_busy.lo_after", 64'(lo), 64'h1E);

        // Seed distinct HI/LO, then cancel a multiply at iteration 10
        issue(OpMthi, 32'hAAAA5555, 32'h0);
        issue(OpMtlo, 32'h0F0F0F0F, 32'h0);
        issue(OpMult, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check_val("cancel.busy", 64'(busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check_val("cancel.no_done", 64'(pulses), 64'd0);
        check_val("cancel.hi", 64'(hi), 64'hAAAA5555);
        check_val("cancel.lo", 64'(lo), 64'h0F0F0F0F);

        // cancel and start together in IDLE: request dropped
        cancel = 1'b1;
        issue(OpMthi, 32'h11111111, 32'h0);
        cancel = 1'b0;
        check_val("cancel_start.hi", 64'(hi), 64'hAAAA5555);

        // done and start in the same cycle: new request accepted
        issue(OpMultu, 32'd3, 32'd4);
        wait_done(n);
        check_val("b2b.first_done", 64'(done), 64'd1);
        check_val("b2b.first_lo", 64'(lo), 64'd12);
        issue(OpDivu, 32'd100, 32'd7);
        check_val("b2b.busy", 64'(busy), 64'd1);
        wait_done(n);
        check_val("b2b.busy_cycles", 64'(n), 64'd33);
        check_val("b2b.hi", 64'(hi), 64'd2);
        check_val("b2b.lo", 64'(lo), 64'd14);
        @(negedge clk);

        // Reset mid-divide clears everything
        issue(OpMthi, 32'hCAFEF00D, 32'h0);
        issue(OpDiv, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_mid.busy", 64'(busy), 64'd0);
        check_val("rst_mid.done", 64'(done), 64'd0);
        check_val("rst_mid.div_zero", 64'(div_zero), 64'd0);
        check_val("rst_mid.hi", 64'(hi), 64'd0);
        check_val("rst_mid.lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Multiply-accumulate
        run_op("madd_pre", OpMult, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
`ifdef MULDIV_MADD_EN
        run_op("madd", OpMadd, 32'd4, 32'd5, 32'd0, 32'h1A, 1'b0);
`else
        issue(OpMadd, 32'd4, 32'd5);
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_seen++;
            @(negedge clk);
        end
        check_val("madd_off.busy", 64'(busy_seen), 64'd0);
        check_val("madd_off.hi", 64'(hi), 64'd0);
        check_val("madd_off.lo", 64'(lo), 64'd6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
